// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor for the CPU ALU path.
// Operands are consumed LSB-first, DIGIT bits per clock, through a ripple
// chain of DIGIT full-adder stages. A start/busy/done handshake frames each
// operation. Sum and the flags are registered and change only when an
// operation completes.
module serial_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic             Neg
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 2) begin : g_bad_width
    $error("serial_addsub: WIDTH must be at least 2");
  end
  if ((DIGIT == 0) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
    $error("serial_addsub: DIGIT must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  // Digit datapath results.
  logic [DIGIT-1:0] dig_sum;
  logic             chain_cout;
  logic             chain_cmsb;
  logic [WIDTH-1:0] res_shift;

  // Ripple chain of DIGIT full-adder stages over the low digit of the operands.
  // chain_cmsb is the carry into the top stage; on the final step the top stage
  // is the MSB full adder, so it feeds the signed-overflow flag.
  always_comb begin
    logic c;
    c          = carry_q;
    chain_cmsb = carry_q;
    dig_sum    = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      chain_cmsb = c;
      dig_sum[i] = opa_q[i] ^ opb_q[i] ^ c;
      c          = (opa_q[i] & opb_q[i]) | (opa_q[i] & c) | (opb_q[i] & c);
    end
    chain_cout = c;
  end

  // New digit enters at the top of the result register; older digits move down.
  always_comb begin
    res_shift = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Subtraction is A + ~B + ~Cin, so Cin doubles as borrow-in.
          opa_d   = A;
          opb_d   = Sub ? ~B : B;
          carry_d = Cin ^ Sub;
          cnt_d   = '0;
          res_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        carry_d = chain_cout;
        res_d   = res_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          sum_d   = res_shift;
          cout_d  = chain_cout;
          ovf_d   = chain_cmsb ^ chain_cout;
          zero_d  = (res_shift == '0);
          neg_d   = res_shift[WIDTH-1];
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, operand and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    busy = (state_q == StRun) || (state_q == StDone);
    done = (state_q == StDone);
    Sum  = sum_q;
    Cout = cout_q;
    Ovf  = ovf_q;
    Zero = zero_q;
    Neg  = neg_q;
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: three instances (DIGIT = 1, 4, 16) share
// operand/reset stimulus and have separate start lines.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_v = '0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        cin_in = 1'b0;
  logic        sub_in = 1'b0;

  logic [2:0]  busy_v, done_v, cout_v, ovf_v, zero_v, neg_v;
  logic [15:0] sum_w [3];

  int vecs = 0;
  int miscmp = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .A(a_in), .B(b_in), .Cin(cin_in),
    .Sub(sub_in), .busy(busy_v[0]), .done(done_v[0]), .Sum(sum_w[0]), .Cout(cout_v[0]),
    .Ovf(ovf_v[0]), .Zero(zero_v[0]), .Neg(neg_v[0])
  );

  serial_addsub #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .A(a_in), .B(b_in), .Cin(cin_in),
    .Sub(sub_in), .busy(busy_v[1]), .done(done_v[1]), .Sum(sum_w[1]), .Cout(cout_v[1]),
    .Ovf(ovf_v[1]), .Zero(zero_v[1]), .Neg(neg_v[1])
  );

  serial_addsub #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst), .start(start_v[2]), .A(a_in), .B(b_in), .Cin(cin_in),
    .Sub(sub_in), .busy(busy_v[2]), .done(done_v[2]), .Sum(sum_w[2]), .Cout(cout_v[2]),
    .Ovf(ovf_v[2]), .Zero(zero_v[2]), .Neg(neg_v[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      miscmp++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {Cout, Ovf, Zero, Neg, Sum} of one instance.
  function automatic logic [31:0] obs_of(input int idx);
    return 32'({cout_v[idx], ovf_v[idx], zero_v[idx], neg_v[idx], sum_w[idx]});
  endfunction

  // Behavioural reference: plain 17-bit arithmetic, overflow from operand signs.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] bb;
    logic [16:0] full;
    logic [15:0] s;
    logic        ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 17'(cin ^ sub);
    s    = full[15:0];
    ovf  = (a[15] == bb[15]) && (s[15] != a[15]);
    return 32'({full[16], ovf, (s == 16'h0000), s[15], s});
  endfunction

  function automatic int steps_of(input int idx);
    return (idx == 0) ? 16 : ((idx == 1) ? 4 : 1);
  endfunction

  // Start one operation on instance idx and wait (bounded) for its done pulse.
  // Returns with done high; held is Sum observed just after the accepting edge.
  task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        output int lat, output int bcnt, output logic [15:0] held);
    a_in         = a;
    b_in         = b;
    cin_in       = cin;
    sub_in       = sub;
    start_v[idx] = 1'b1;
    tick();
    start_v[idx] = 1'b0;
    lat          = 0;
    bcnt         = 0;
    held         = sum_w[idx];
    while ((done_v[idx] !== 1'b1) && (lat < 40)) begin
      if (busy_v[idx] === 1'b1) bcnt++;
      tick();
      lat++;
    end
    if (busy_v[idx] === 1'b1) bcnt++;
  endtask

  initial begin
    int          lat;
    int          bcnt;
    int          dcnt;
    logic [15:0] held;
    logic [15:0] ra, rb;
    logic        rc, rs;
    logic [15:0] prev [3];
    logic [2:0]  pvalid;

    // Reset state.
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("reset_flags_sum", obs_of(i), 32'h0);
      chk("reset_busy_done", 32'({busy_v[i], done_v[i]}), 32'h0);
    end
    rst = 1'b0;
    tick();

    // 0x7FFF + 1: signed overflow into negative, 16-cycle latency.
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, bcnt, held);
    chk("add_7fff_lat", 32'(lat), 32'd16);
    chk("add_7fff_busy", 32'(bcnt), 32'd17);
    chk("add_7fff_done", 32'(done_v[0]), 32'h1);
    chk("add_7fff_res", obs_of(0), 32'h58000);
    tick();
    chk("add_7fff_idle", 32'({busy_v[0], done_v[0]}), 32'h0);
    chk("add_7fff_hold", obs_of(0), 32'h58000);

    // Subtractions on the DIGIT=4 instance.
    run_op(1, 16'h0005, 16'h0005, 1'b0, 1'b1, lat, bcnt, held);
    chk("sub_5_5_lat", 32'(lat), 32'd4);
    chk("sub_5_5_res", obs_of(1), 32'hA0000);
    tick();
    run_op(1, 16'h0000, 16'h0001, 1'b0, 1'b1, lat, bcnt, held);
    chk("sub_0_1_res", obs_of(1), 32'h1FFFF);
    tick();
    run_op(1, 16'h0010, 16'h0001, 1'b1, 1'b1, lat, bcnt, held);
    chk("sub_10_1_bin_res", obs_of(1), 32'h8000E);
    tick();
    run_op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, lat, bcnt, held);
    chk("sub_8000_1_res", obs_of(1), 32'hC7FFF);
    tick();

    // 0xFFFF + 1 wrap on DIGIT=4 and DIGIT=16.
    run_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bcnt, held);
    chk("d4_wrap_lat", 32'(lat), 32'd4);
    chk("d4_wrap_res", obs_of(1), 32'hA0000);
    tick();
    run_op(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bcnt, held);
    chk("d16_wrap_lat", 32'(lat), 32'd1);
    chk("d16_wrap_res", obs_of(2), 32'hA0000);
    tick();
    chk("d16_idle", 32'({busy_v[2], done_v[2]}), 32'h0);

    // Starts during RUN and DONE are ignored; operand changes have no effect.
    a_in       = 16'h0001;
    b_in       = 16'h0001;
    cin_in     = 1'b0;
    sub_in     = 1'b0;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    a_in       = 16'h1234;
    b_in       = 16'h1111;
    cin_in     = 1'b1;
    sub_in     = 1'b1;
    dcnt       = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_v[0] === 1'b1) begin
        dcnt++;
        chk("ignore_sum", obs_of(0), 32'h00002);
        start_v[0] = 1'b1;
      end else begin
        start_v[0] = (i == 3) || (i == 9);
      end
      tick();
    end
    start_v[0] = 1'b0;
    chk("ignore_done_count", 32'(dcnt), 32'd1);
    chk("ignore_idle", 32'({busy_v[0], done_v[0]}), 32'h0);
    chk("ignore_hold", obs_of(0), 32'h00002);

    // Asynchronous reset at step 7 of a 16-step add.
    a_in       = 16'h1234;
    b_in       = 16'h1111;
    cin_in     = 1'b0;
    sub_in     = 1'b0;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", obs_of(0), 32'h0);
    chk("midrst_busy_done", 32'({busy_v[0], done_v[0]}), 32'h0);
    chk("midrst_other", obs_of(1), 32'h0);
    #1;
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (done_v[0] === 1'b1) dcnt++;
      tick();
    end
    chk("midrst_no_done", 32'(dcnt), 32'd0);
    run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, lat, bcnt, held);
    chk("post_rst_lat", 32'(lat), 32'd16);
    chk("post_rst_res", obs_of(0), 32'h00100);
    tick();

    // Random regression across all three instances against the model.
    pvalid = '0;
    for (int n = 0; n < 600; n++) begin
      int idx;
      idx = n % 3;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rc  = 1'($urandom);
      rs  = 1'($urandom);
      run_op(idx, ra, rb, rc, rs, lat, bcnt, held);
      chk("rand_lat", 32'(lat), 32'(steps_of(idx)));
      chk("rand_res", obs_of(idx), model(ra, rb, rc, rs));
      if (pvalid[idx]) chk("rand_hold_in_run", 32'(held), 32'(prev[idx]));
      prev[idx]   = sum_w[idx];
      pvalid[idx] = 1'b1;
      tick();
      chk("rand_hold_after_done", 32'(sum_w[idx]), 32'(prev[idx]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
